// File: rtl/rr_encoder_32to5.sv
// rr_encoder_32to5 -- registered 32-to-5 request encoder with valid/ready output.
//
// Picks one set bit of `request` and presents its index on `code` behind a
// valid/ready handshake. It is the inverse of the register-file 5-bit address
// decoder and lets several requesters share one 5-bit address port.
//
// Optional feature macro: RR_PRIORITY_EN
//   defined   : round-robin. The scan starts at `ptr`, and ptr <= code+1 on each handshake.
//   undefined : fixed priority (lowest set index wins), and ptr reads 0.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   request    in   [N_REQ-1:0] request vector, bit i = index i wants service
//   code       out  [CODE_W-1:0] granted index
//   code_valid out  code holds a grant
//   code_ready in   consumer accepts code this cycle
//   multi      out  >=2 request bits were set when code was loaded
//   ptr        out  [CODE_W-1:0] round-robin start pointer (visibility)
module rr_encoder_32to5 #(
  parameter int N_REQ  = 32,
  parameter int CODE_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_REQ-1:0]  request,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              multi,
  output logic [CODE_W-1:0] ptr
);

  logic                hs;
  logic                slot_free;
  logic                any_req;
  logic                many_req;
  logic [2*N_REQ-1:0]  dbl;
  logic [2*N_REQ-1:0]  dbl_sh;
  logic [N_REQ-1:0]    rot;
  logic [CODE_W-1:0]   off;
  logic [CODE_W-1:0]   sel;

  assign hs        = code_valid & code_ready;
  assign slot_free = ~code_valid | code_ready;
  assign any_req   = |request;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign many_req  = |(request & (request - N_REQ'(1)));

  // Rotate the request vector so that bit ptr lands at position 0. A
  // fixed-priority search on the rotated vector then gives the offset from ptr.
  assign dbl    = {request, request};
  assign dbl_sh = dbl >> ptr;
  assign rot    = dbl_sh[N_REQ-1:0];

  always_comb begin
    off = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (rot[i]) off = CODE_W'(i);
  end

  // The CODE_W-bit add wraps modulo N_REQ (N_REQ == 2**CODE_W).
  assign sel = ptr + off;

  // Output register. A held grant (valid && !ready) is sticky. It ignores the
  // request vector until the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code       <= '0;
      code_valid <= 1'b0;
      multi      <= 1'b0;
    end else if (slot_free) begin
      if (any_req) begin
        code       <= sel;
        code_valid <= 1'b1;
        multi      <= many_req;
      end else begin
        code_valid <= 1'b0;
      end
    end
  end

`ifdef RR_PRIORITY_EN
  // The pointer advances only on an accepted grant. A load on the same edge
  // still selects with the pre-update value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else if (hs)
      ptr <= code + CODE_W'(1);
  end
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_rr_encoder_32to5.sv
module tb_rr_encoder_32to5;

  logic        clk;
  logic        reset_n;
  logic [31:0] request;
  logic [4:0]  code;
  logic        code_valid;
  logic        code_ready;
  logic        multi;
  logic [4:0]  ptr;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] req;
    logic        rdy;
    logic [4:0]  code;
    logic        vld;
    logic        mul;
    logic [4:0]  ptr_rr;   // expected ptr in round-robin build; fixed build expects 0
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  rr_encoder_32to5 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .request    (request),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .multi      (multi),
    .ptr        (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] req, input logic rdy, input logic [4:0] c,
                              input logic v, input logic m, input logic [4:0] p);
    vec_t r;
    r.req = req; r.rdy = rdy; r.code = c; r.vld = v; r.mul = m; r.ptr_rr = p;
    return r;
  endfunction

  // One clock: drive inputs, queue the expected post-edge outputs, then pop
  // and compare them just after the edge.
  task automatic step(input vec_t v, input string nm);
    vec_t e;
    request    = v.req;
    code_ready = v.rdy;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, ".code"},  32'(code),       32'(e.code));
    chk({nm, ".valid"}, 32'(code_valid), 32'(e.vld));
    chk({nm, ".multi"}, 32'(multi),      32'(e.mul));
`ifdef RR_PRIORITY_EN
    chk({nm, ".ptr"},   32'(ptr),        32'(e.ptr_rr));
`else
    chk({nm, ".ptr"},   32'(ptr),        32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    request = '0;
    code_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    request = '0;
    code_ready = 1'b0;
    #1;
    chk("por.code",  32'(code),       32'd0);
    chk("por.valid", 32'(code_valid), 32'd0);
    chk("por.multi", 32'(multi),      32'd0);
    chk("por.ptr",   32'(ptr),        32'd0);
    #13;
    reset_n = 1'b1;

    //            req           rdy  code vld mul ptr_rr
    vecs.push_back(mk(32'h0,        0, 5'd0, 0, 0, 5'd0));  // idle after reset
    vecs.push_back(mk(32'h100,      1, 5'd8, 1, 0, 5'd0));  // ready with no valid is ignored
    vecs.push_back(mk(32'h100,      1, 5'd8, 1, 0, 5'd9));  // handshake and reload on the same edge
    vecs.push_back(mk(32'h0,        1, 5'd8, 0, 0, 5'd9));  // handshake, then idle
    vecs.push_back(mk(32'h20,       0, 5'd5, 1, 0, 5'd9));  // load 5 under backpressure
    vecs.push_back(mk(32'h20,       0, 5'd5, 1, 0, 5'd9));
    vecs.push_back(mk(32'h20,       0, 5'd5, 1, 0, 5'd9));
    vecs.push_back(mk(32'h20,       0, 5'd5, 1, 0, 5'd9));
    vecs.push_back(mk(32'h20,       0, 5'd5, 1, 0, 5'd9));
    vecs.push_back(mk(32'h0,        0, 5'd5, 1, 0, 5'd9));  // request dropped, grant sticks
    vecs.push_back(mk(32'h0,        1, 5'd5, 0, 0, 5'd6));  // accepted
    vecs.push_back(mk(32'h6,        0, 5'd1, 1, 1, 5'd6));  // scan wraps past 31 to bit 1
    vecs.push_back(mk(32'h0,        1, 5'd1, 0, 1, 5'd2));  // multi keeps its old value
    vecs.push_back(mk(32'hFFFF_FFFF,0, 5'd2, 1, 1, 5'd2));  // all set: ptr 2 in round-robin...
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
`ifndef RR_PRIORITY_EN
      if (v.req == 32'hFFFF_FFFF) v.code = 5'd0;   // ...lowest index in fixed priority
`endif
      step(v, $sformatf("vec%0d", i));
    end

    // Alternate load and accept cycles on the same three requesters.
    do_reset();
    begin
      logic [4:0] rr_seq [6];
      logic [4:0] p_after;
      rr_seq = '{5'd0, 5'd1, 5'd31, 5'd0, 5'd1, 5'd31};
      p_after = 5'd0;
      for (int k = 0; k < 6; k++) begin
        logic [4:0] c;
`ifdef RR_PRIORITY_EN
        c = rr_seq[k];
`else
        c = 5'd0;
`endif
        step(mk(32'h8000_0003, 0, c, 1, 1, p_after), $sformatf("rr_load%0d", k));
        p_after = c + 5'd1;
        step(mk(32'h0, 1, c, 0, 1, p_after), $sformatf("rr_ack%0d", k));
      end
    end

    // Pointer wrap: grant 30 moves ptr to 31, then 31 wraps ptr to 0.
    do_reset();
    step(mk(32'h4000_0000, 0, 5'd30, 1, 0, 5'd0),  "wrap.g30");
    step(mk(32'h0,         1, 5'd30, 0, 0, 5'd31), "wrap.a30");
`ifdef RR_PRIORITY_EN
    step(mk(32'h8000_0001, 0, 5'd31, 1, 1, 5'd31), "wrap.g31");
    step(mk(32'h0,         1, 5'd31, 0, 1, 5'd0),  "wrap.a31");
`else
    step(mk(32'h8000_0001, 0, 5'd0,  1, 1, 5'd0),  "wrap.g31");
    step(mk(32'h0,         1, 5'd0,  0, 1, 5'd0),  "wrap.a31");
`endif
    step(mk(32'h8000_0001, 0, 5'd0,  1, 1, 5'd0),  "wrap.g0");

    // Asynchronous reset in the middle of a held grant.
    do_reset();
    step(mk(32'h80, 0, 5'd7, 1, 0, 5'd0), "hold7.a");
    step(mk(32'h80, 0, 5'd7, 1, 0, 5'd0), "hold7.b");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.code",  32'(code),       32'd0);
    chk("arst.valid", 32'(code_valid), 32'd0);
    chk("arst.multi", 32'(multi),      32'd0);
    chk("arst.ptr",   32'(ptr),        32'd0);
    @(negedge clk);
    request = '0;
    reset_n = 1'b1;
    step(mk(32'h0, 0, 5'd0, 0, 0, 5'd0), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
